// File: rtl/denise_clut_sequencer.sv
// Denise colour lookup RAM access sequencer: shares the single RAM port between COLORxx writes,
// a bulk palette loader, an auto-clear sweep and (MINIMIG_CLUT_READBACK_EN) host readback.
module denise_clut_sequencer #(
    parameter logic [8:0] COLORBASE = 9'h180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [11:0] data_in,
    input  logic [2:0]  bank,
    input  logic        loct,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_adr,
    input  logic [23:0] ld_dat,
    input  logic        clr_req,
    output logic        clr_done,
    input  logic        rb_req,
    input  logic [7:0]  rb_adr,
    output logic        rb_ack,
    output logic [23:0] rb_dat,
    output logic [7:0]  clut_wr_adr,
    output logic        clut_wr_en,
    output logic [31:0] clut_wr_dat,
    output logic [3:0]  clut_wr_bs,
    output logic        clut_rdram,
    input  logic [31:0] clut_rd_dat,
    output logic        busy
);

`ifdef MINIMIG_CLUT_READBACK_EN
    typedef enum logic [1:0] {StIdle, StClear, StRbRd, StRbCap} state_t;
`else
    typedef enum logic [1:0] {StIdle, StClear} state_t;
`endif

    state_t      state;
    logic        hold_full;
    logic [7:0]  hold_adr;
    logic [31:0] hold_dat;
    logic [3:0]  hold_bs;
    logic        clr_pend;
    logic [7:0]  cnt;

    logic capture;
    logic drain;
    logic rb_go;
    logic busy_nx;

    assign capture = clk7_en && (reg_address_in[8:6] == COLORBASE[8:6]);
    assign drain   = hold_full && (state == StIdle || state == StClear);

`ifdef MINIMIG_CLUT_READBACK_EN
    logic unused_rd_bits;
    assign rb_go          = rb_req;
    assign unused_rd_bits = ^{clut_rd_dat[31:28], clut_rd_dat[15:12]};
`else
    logic unused_rb;
    assign rb_go      = 1'b0;
    assign rb_ack     = 1'b0;
    assign rb_dat     = 24'h0;
    assign clut_rdram = 1'b0;
    assign unused_rb  = ^{rb_req, rb_adr, clut_rd_dat};
`endif

    assign ld_ready = !reset && state == StIdle && !hold_full && !rb_go && !clr_pend && !capture;

    // busy mirrors the state and HOLD occupancy that the coming edge will produce
    always_comb begin
        busy_nx = capture || (hold_full && !drain);
        case (state)
            StIdle:  if (!hold_full && (rb_go || clr_pend)) busy_nx = 1'b1;
            StClear: if (hold_full || cnt != 8'hFF) busy_nx = 1'b1;
`ifdef MINIMIG_CLUT_READBACK_EN
            StRbRd:  busy_nx = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            hold_full   <= 1'b0;
            hold_adr    <= 8'h0;
            hold_dat    <= 32'h0;
            hold_bs     <= 4'h0;
            clr_pend    <= 1'b0;
            cnt         <= 8'h0;
            clr_done    <= 1'b0;
            clut_wr_adr <= 8'h0;
            clut_wr_en  <= 1'b0;
            clut_wr_dat <= 32'h0;
            clut_wr_bs  <= 4'h0;
            busy        <= 1'b0;
`ifdef MINIMIG_CLUT_READBACK_EN
            rb_ack      <= 1'b0;
            rb_dat      <= 24'h0;
            clut_rdram  <= 1'b0;
`endif
        end else begin
            clut_wr_en <= 1'b0;
            clr_done   <= 1'b0;
            busy       <= busy_nx;
`ifdef MINIMIG_CLUT_READBACK_EN
            rb_ack     <= 1'b0;
            clut_rdram <= 1'b0;
`endif
            // a capture on the drain edge replaces the entry being written out
            if (capture) begin
                hold_full <= 1'b1;
                hold_adr  <= {bank, reg_address_in[5:1]};
                hold_dat  <= {4'b0, data_in, 4'b0, data_in};
                hold_bs   <= loct ? 4'b0011 : 4'b1111;
            end else if (drain) begin
                hold_full <= 1'b0;
            end

            if (clr_req && state != StClear) clr_pend <= 1'b1;

            if (drain) begin
                clut_wr_en  <= 1'b1;
                clut_wr_adr <= hold_adr;
                clut_wr_dat <= hold_dat;
                clut_wr_bs  <= hold_bs;
            end else begin
                case (state)
                    StIdle: begin
                        if (rb_go) begin
`ifdef MINIMIG_CLUT_READBACK_EN
                            state       <= StRbRd;
                            clut_rdram  <= 1'b1;
                            clut_wr_adr <= rb_adr;
`endif
                        end else if (clr_pend) begin
                            state    <= StClear;
                            cnt      <= 8'h0;
                            clr_pend <= 1'b0;
                        end else if (ld_valid && ld_ready) begin
                            clut_wr_en  <= 1'b1;
                            clut_wr_adr <= ld_adr;
                            clut_wr_dat <= {4'b0, ld_dat[23:20], ld_dat[15:12], ld_dat[7:4],
                                            4'b0, ld_dat[19:16], ld_dat[11:8], ld_dat[3:0]};
                            clut_wr_bs  <= 4'b1111;
                        end
                    end
                    StClear: begin
                        clut_wr_en  <= 1'b1;
                        clut_wr_adr <= cnt;
                        clut_wr_dat <= 32'h0;
                        clut_wr_bs  <= 4'b1111;
                        cnt         <= cnt + 8'd1;
                        if (cnt == 8'hFF) begin
                            clr_done <= 1'b1;
                            state    <= StIdle;
                        end
                    end
`ifdef MINIMIG_CLUT_READBACK_EN
                    StRbRd: begin
                        clut_rdram <= 1'b1;
                        state      <= StRbCap;
                    end
                    StRbCap: begin
                        rb_ack <= 1'b1;
                        rb_dat <= {clut_rd_dat[27:24], clut_rd_dat[11:8], clut_rd_dat[23:20],
                                   clut_rd_dat[7:4], clut_rd_dat[19:16], clut_rd_dat[3:0]};
                        state  <= StIdle;
                    end
`endif
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/denise_clut_sequencer.md
# denise_clut_sequencer

Access controller for Denise's 256-entry colour lookup RAM. The lookup RAM has a single write/readback address port. This block shares that port between three requesters:
- Custom-register COLORxx writes, with BPLCON3 bank and LOCT applied.
- A 24-bit bulk palette loader stream, used by the OSD and savestate path.
- A host readback port.

It also runs an auto-incrementing clear sequence. It sits between the register bus and the colour table RAM, and drives the RAM's write and readback controls.

## Interface
Parameters:
- COLORBASE, 9'h180, base address of the COLOR00–COLOR31 register block.

Ports:
- clk  in  1  28MHz clock
- reset  in  1  synchronous, active-high reset
- clk7_en  in  1  7MHz clock enable
- reg_address_in  in  8 [8:1]  register address
- data_in  in  12  register data
- bank  in  3  BPLCON3 colour bank
- loct  in  1  BPLCON3 low-nibble write select
- ld_valid  in  1  loader entry valid
- ld_ready  out  1  loader entry accepted this cycle
- ld_adr  in  8  loader entry index
- ld_dat  in  24  loader colour {R8,G8,B8}
- clr_req  in  1  start clear (pulse)
- clr_done  out  1  one-cycle pulse when the clear finishes
- rb_req  in  1  readback request (level)
- rb_adr  in  8  readback index
- rb_ack  out  1  one-cycle pulse, rb_dat valid
- rb_dat  out  24  readback colour {R8,G8,B8}
- clut_wr_adr  out  8  RAM write/readback address
- clut_wr_en  out  1  RAM write enable
- clut_wr_dat  out  32  RAM data {4'b0,hi12,4'b0,lo12}
- clut_wr_bs  out  4  RAM byte enables
- clut_rdram  out  1  RAM readback mode; the RAM reads at clut_wr_adr
- clut_rd_dat  in  32  RAM read data, one cycle after the address
- busy  out  1  FSM not IDLE, or the holding register is full

## Operation
- **Register capture**
  - Trigger: clk7_en=1 and reg_address_in[8:6]==COLORBASE[8:6].
  - Captured into a 1-entry holding register (HOLD): adr={bank,reg_address_in[5:1]}, dat={4'b0,data_in,4'b0,data_in}, bs=loct?4'b0011:4'b1111.
  - HOLD drains at the next decision point. It always beats the loader, clear and readback start.
  - A capture arriving in the same cycle HOLD drains overwrites it cleanly; the new entry is kept.
- **Decision point:** every cycle in IDLE or CLEAR. Priority order: HOLD drain > readback start > clear step > loader.
- **States:**
  - **IDLE**
    - HOLD full → write HOLD.
    - Else rb_req → RB_RD.
    - Else clr_req latched → CLEAR (counter=0).
    - Else ld_valid → ld_ready=1, write the loader entry.
  - **CLEAR**
    - Each cycle without a HOLD drain writes counter with data 0 and bs 4'b1111, then increments the counter.
    - After index 255 is written: clr_done pulses, → IDLE.
    - clr_req during CLEAR is ignored.
    - rb_req and the loader wait until the clear completes.
  - **RB_RD**
    - clut_rdram=1, clut_wr_adr=rb_adr, clut_wr_en=0. → RB_CAP.
  - **RB_CAP**
    - rdram and address held.
    - Capture at the end of the cycle: hi=clut_rd_dat[27:16], lo=clut_rd_dat[11:0]. rb_dat={hi[11:8],lo[11:8],hi[7:4],lo[7:4],hi[3:0],lo[3:0]}.
    - → IDLE with rb_ack.
    - Readback is never interrupted. HOLD waits at most 2 cycles, which is less than the 4-cycle clk7_en period, so HOLD cannot overflow.
- **Loader write:** hi={R[7:4],G[7:4],B[7:4]}, lo={R[3:0],G[3:0],B[3:0]}, bs=4'b1111.
- **Reset:** state=IDLE, HOLD empty, clr latch 0, counter 0. All outputs 0, including ld_ready, rb_ack, clr_done, rb_dat and busy.
- **Reset mid-clear or mid-readback:** the operation is abandoned. No clr_done, no rb_ack.

## Timing
- All outputs are registered.
- **Register write:** clk7_en sample at edge E. With HOLD drained immediately, clut_wr_en is high for exactly one cycle after E. Worst case 3 cycles after E.
- **Loader:** ld_ready is combinational. It is high only in IDLE with HOLD empty, no rb_req, no pending clear, and no capture this cycle. The transfer happens when ld_valid&&ld_ready. clut_wr_en follows in the next cycle. Throughput is one entry per cycle.
- **Readback:** rb_req seen in IDLE at edge E0 gives clut_rdram high for cycles 1–2 and rb_ack for cycle 3 (latency 3). rb_dat holds until the next ack. rb_req must drop or change rb_adr after the ack, otherwise the readback repeats.
- **Clear:** ≥256 cycles. Each HOLD drain during CLEAR adds one cycle.
- clut_wr_en and clut_rdram are never high in the same cycle.

## Configuration
- MINIMIG_CLUT_READBACK_EN
  - Defined: readback path as specified.
  - Undefined: RB_RD and RB_CAP are removed, rb_req is ignored, and rb_ack, rb_dat and clut_rdram are tied to 0.

## Test plan
- Reset, then COLOR05=12'hABC with bank=3'd2, loct=0 → one write at adr 8'h45, dat 32'h0ABC0ABC, bs 4'hF. Repeat with loct=1 → bs 4'h3.
- Loader streams 4 entries 10–13, ld_dat=24'h123456 → four consecutive writes, each dat 32'h01350246.
- Register write collides with loader traffic → ld_ready low in the capture and drain cycles. Register write issued first; no loader entry lost.
- clr_req, plus a COLOR00 write at cycle 100 → 256 zero writes and one HOLD write. clr_done at cycle 258±1, each index written exactly once.
- Readback of entry 8'h45 after a write of 12'hABC (loct=0) → rb_ack at latency 3, rb_dat=24'hAABBCC, with a register write landing 2 cycles after the ack.
- Reset asserted in CLEAR at counter 100 → all outputs 0 in the next cycle, and no clr_done ever.
